// File: rtl/note_sequencer.sv
// note_sequencer: walks a song ROM of {end, pitch, len} entries, asks the
// note length table how long each note lasts, and gates the tone generator
// for that many cycles. A song either plays once or repeats until stopped.
module note_sequencer #(
    parameter int ADDR_WIDTH  = 6,
    parameter int PITCH_WIDTH = 6,
    parameter int GAP_CYCLES  = 0,
    parameter int LOOP        = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_stop,
    output logic [ADDR_WIDTH-1:0]  o_rom_addr,
    input  logic [PITCH_WIDTH+5:0] i_rom_data,
    output logic [4:0]             o_note_len,
    input  logic [31:0]            i_duration,
    output logic [PITCH_WIDTH-1:0] o_pitch,
    output logic                   o_note_on,
    output logic                   o_note_strobe,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ARM,
        PLAY
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [PITCH_WIDTH-1:0] notePitch_q, notePitch_d;
    logic [4:0]             len_q, len_d;
    logic [PITCH_WIDTH-1:0] pitch_q, pitch_d;
    logic                   strobe_q, strobe_d;
    logic                   done_q, done_d;

    logic                   romEnd;
    logic [PITCH_WIDTH-1:0] romPitch;
    logic [4:0]             romLen;
    logic [31:0]            noteCycles;

    assign romEnd   = i_rom_data[PITCH_WIDTH+5];
    assign romPitch = i_rom_data[PITCH_WIDTH+4:5];
    assign romLen   = i_rom_data[4:0];

    // A zero-length entry in the table still plays for a single cycle.
    assign noteCycles = (i_duration == 32'd0) ? 32'd1 : i_duration;

    assign o_rom_addr    = addr_q;
    assign o_note_len    = len_q;
    assign o_pitch       = pitch_q;
    assign o_note_strobe = strobe_q;
    assign o_done        = done_q;
    assign o_busy        = (state_q != IDLE);
    assign o_note_on     = (state_q == PLAY) && (pitch_q != '0) &&
                           (cnt_q >= 32'(GAP_CYCLES));

    // State register and datapath registers; reset returns everything to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            notePitch_q <= '0;
            len_q       <= '0;
            pitch_q     <= '0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            notePitch_q <= notePitch_d;
            len_q       <= len_d;
            pitch_q     <= pitch_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: fetch, decode, arm the note timer, count it out; stop overrides all.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        notePitch_d = notePitch_q;
        len_d       = len_q;
        pitch_d     = pitch_q;
        strobe_d    = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = FETCH;
                    addr_d  = '0;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (romEnd) begin
                    if (addr_q == '0) begin
                        state_d = IDLE;
                    end else if (LOOP != 0) begin
                        addr_d  = '0;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    notePitch_d = romPitch;
                    len_d       = romLen;
                    state_d     = ARM;
                end
            end
            ARM: begin
                cnt_d    = noteCycles - 32'd1;
                pitch_d  = notePitch_q;
                strobe_d = 1'b1;
                state_d  = PLAY;
            end
            PLAY: begin
                if (cnt_q == 32'd0) begin
                    state_d = FETCH;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (i_stop) begin
            state_d  = IDLE;
            addr_d   = '0;
            cnt_d    = '0;
            pitch_d  = '0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: one play-once instance (no gap) and one
// looping instance with a two-cycle gap, each with its own song ROM and a
// stubbed note length table.
module tb_note_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        startA, stopA, startB, stopB;

    logic [11:0] romA [64];
    logic [11:0] romB [64];
    logic [11:0] romDataA, romDataB;

    logic [5:0]  addrA, addrB;
    logic [4:0]  noteLenA, noteLenB;
    logic [31:0] durA, durB;
    logic [5:0]  pitchA, pitchB;
    logic        noteOnA, noteOnB, strobeA, strobeB;
    logic        busyA, busyB, doneA, doneB;

    logic        sel;
    logic [5:0]  sAddr, sPitch;
    logic        sNoteOn, sStrobe, sBusy, sDone;

    int vectors = 0;
    int miscompares = 0;

    int strobeAt [8];
    int pitchAt  [8];
    int onCnt    [8];
    int nStrobe;
    int doneCnt;
    int idleAt;
    bit timedOut;

    always #5 clock = ~clock;

    // Stubbed note length table: maps a len code to a cycle count.
    function automatic logic [31:0] durOf(input logic [4:0] len);
        case (len)
            5'd0:    return 32'd4;
            5'd1:    return 32'd6;
            5'd2:    return 32'd5;
            5'd3:    return 32'd2;
            5'd4:    return 32'd0;
            default: return 32'd3;
        endcase
    endfunction

    function automatic logic [11:0] ent(input logic e, input logic [5:0] p, input logic [4:0] l);
        return {e, p, l};
    endfunction

    assign durA = durOf(noteLenA);
    assign durB = durOf(noteLenB);

    // Song ROMs with one cycle of read latency.
    always @(posedge clock) begin
        romDataA <= romA[addrA];
        romDataB <= romB[addrB];
    end

    assign sAddr   = sel ? addrB   : addrA;
    assign sPitch  = sel ? pitchB  : pitchA;
    assign sNoteOn = sel ? noteOnB : noteOnA;
    assign sStrobe = sel ? strobeB : strobeA;
    assign sBusy   = sel ? busyB   : busyA;
    assign sDone   = sel ? doneB   : doneA;

    note_sequencer #(
        .ADDR_WIDTH (6),
        .PITCH_WIDTH(6),
        .GAP_CYCLES (0),
        .LOOP       (0)
    ) dutA (
        .i_clk        (clock),
        .i_rst        (reset),
        .i_start      (startA),
        .i_stop       (stopA),
        .o_rom_addr   (addrA),
        .i_rom_data   (romDataA),
        .o_note_len   (noteLenA),
        .i_duration   (durA),
        .o_pitch      (pitchA),
        .o_note_on    (noteOnA),
        .o_note_strobe(strobeA),
        .o_busy       (busyA),
        .o_done       (doneA)
    );

    note_sequencer #(
        .ADDR_WIDTH (6),
        .PITCH_WIDTH(6),
        .GAP_CYCLES (2),
        .LOOP       (1)
    ) dutB (
        .i_clk        (clock),
        .i_rst        (reset),
        .i_start      (startB),
        .i_stop       (stopB),
        .o_rom_addr   (addrB),
        .i_rom_data   (romDataB),
        .o_note_len   (noteLenB),
        .i_duration   (durB),
        .o_pitch      (pitchB),
        .o_note_on    (noteOnB),
        .o_note_strobe(strobeB),
        .o_busy       (busyB),
        .o_done       (doneB)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive start/stop of the selected instance for exactly one clock edge.
    task automatic applyStimulus(input logic which, input logic st, input logic sp);
        if (which) begin
            startB = st;
            stopB  = sp;
        end else begin
            startA = st;
            stopA  = sp;
        end
        tick();
        startA = 1'b0;
        stopA  = 1'b0;
        startB = 1'b0;
        stopB  = 1'b0;
    endtask

    // Record strobes, pitches, note-on cycles per note and done pulses of the
    // selected instance until it goes idle or reaches stopStrobes strobes.
    task automatic runCapture(input int maxCycles, input int stopStrobes);
        nStrobe  = 0;
        doneCnt  = 0;
        idleAt   = -1;
        timedOut = 1'b1;
        for (int i = 0; i < 8; i++) begin
            strobeAt[i] = -1;
            pitchAt[i]  = -1;
            onCnt[i]    = 0;
        end
        for (int c = 1; c <= maxCycles; c++) begin
            tick();
            if (sStrobe) begin
                if (nStrobe < 8) begin
                    strobeAt[nStrobe] = c;
                    pitchAt[nStrobe]  = int'(sPitch);
                end
                nStrobe++;
            end
            if (sNoteOn && nStrobe > 0 && nStrobe <= 8) onCnt[nStrobe-1]++;
            if (sDone) doneCnt++;
            if (!sBusy) begin
                idleAt   = c;
                timedOut = 1'b0;
                break;
            end
            if (stopStrobes > 0 && nStrobe >= stopStrobes) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        sel    = 1'b0;
        reset  = 1'b1;
        startA = 1'b0;
        stopA  = 1'b0;
        startB = 1'b0;
        stopB  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            romA[i] = ent(1'b1, 6'd0, 5'd0);
            romB[i] = ent(1'b1, 6'd0, 5'd0);
        end

        tick();
        tick();
        checkOutput("reset busy",   int'(busyA),   0);
        checkOutput("reset addr",   int'(addrA),   0);
        checkOutput("reset noteon", int'(noteOnA), 0);
        checkOutput("reset pitch",  int'(pitchA),  0);
        checkOutput("reset strobe", int'(strobeA), 0);
        checkOutput("reset done",   int'(doneA),   0);
        reset = 1'b0;
        tick();

        $display("[TB] play-once song: pitch 5 for 4 cycles, pitch 9 for 6 cycles");
        romA[0] = ent(1'b0, 6'd5, 5'd0);
        romA[1] = ent(1'b0, 6'd9, 5'd1);
        romA[2] = ent(1'b1, 6'd0, 5'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("busy after start", int'(busyA), 1);
        runCapture(60, 0);
        checkOutput("song A bounded",    int'(timedOut), 0);
        checkOutput("song A strobes",    nStrobe, 2);
        checkOutput("song A gap",        strobeAt[1] - strobeAt[0], 7);
        checkOutput("song A pitch0",     pitchAt[0], 5);
        checkOutput("song A pitch1",     pitchAt[1], 9);
        checkOutput("song A noteon0",    onCnt[0], 4);
        checkOutput("song A noteon1",    onCnt[1], 6);
        checkOutput("song A done count", doneCnt, 1);
        checkOutput("song A idle cycle", idleAt, 18);
        tick();
        checkOutput("song A done pulse", int'(doneA), 0);
        checkOutput("song A busy low",   int'(busyA), 0);
        checkOutput("song A pitch hold", int'(pitchA), 9);

        $display("[TB] zero-duration notes play one cycle each");
        romA[0] = ent(1'b0, 6'd7, 5'd4);
        romA[1] = ent(1'b0, 6'd3, 5'd4);
        romA[2] = ent(1'b1, 6'd0, 5'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCapture(60, 0);
        checkOutput("dur0 bounded", int'(timedOut), 0);
        checkOutput("dur0 gap",     strobeAt[1] - strobeAt[0], 4);
        checkOutput("dur0 noteon0", onCnt[0], 1);
        checkOutput("dur0 noteon1", onCnt[1], 1);

        $display("[TB] empty song");
        romA[0] = ent(1'b1, 6'd0, 5'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCapture(20, 0);
        checkOutput("empty idle cycle", idleAt, 2);
        checkOutput("empty strobes",    nStrobe, 0);
        checkOutput("empty no done",    doneCnt, 0);

        $display("[TB] start and stop together");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("start+stop busy", int'(busyA), 0);
        tick();
        checkOutput("start+stop still idle", int'(busyA), 0);

        $display("[TB] reset during the second note");
        romA[0] = ent(1'b0, 6'd5, 5'd0);
        romA[1] = ent(1'b0, 6'd9, 5'd1);
        romA[2] = ent(1'b1, 6'd0, 5'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCapture(60, 2);
        checkOutput("pre-reset bounded", int'(timedOut), 0);
        checkOutput("pre-reset addr",    int'(addrA), 1);
        checkOutput("pre-reset noteon",  int'(noteOnA), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid reset busy",   int'(busyA),   0);
        checkOutput("mid reset addr",   int'(addrA),   0);
        checkOutput("mid reset noteon", int'(noteOnA), 0);
        checkOutput("mid reset pitch",  int'(pitchA),  0);
        checkOutput("mid reset strobe", int'(strobeA), 0);
        checkOutput("mid reset len",    int'(noteLenA), 0);

        $display("[TB] looping song with gap of two");
        sel = 1'b1;
        romB[0] = ent(1'b0, 6'd5, 5'd0);
        romB[1] = ent(1'b0, 6'd9, 5'd1);
        romB[2] = ent(1'b1, 6'd0, 5'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCapture(80, 3);
        checkOutput("loop bounded",    int'(timedOut), 0);
        checkOutput("loop pitch2",     pitchAt[2], 5);
        checkOutput("loop gap",        strobeAt[2] - strobeAt[1], 11);
        checkOutput("loop addr wrap",  int'(addrB), 0);
        checkOutput("loop noteon0",    onCnt[0], 2);
        checkOutput("loop noteon1",    onCnt[1], 4);
        checkOutput("loop no done",    doneCnt, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("loop stopped", int'(busyB), 0);

        $display("[TB] gap edge cases and rest");
        romB[0] = ent(1'b0, 6'd12, 5'd2);
        romB[1] = ent(1'b0, 6'd4,  5'd3);
        romB[2] = ent(1'b0, 6'd0,  5'd2);
        romB[3] = ent(1'b1, 6'd0,  5'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCapture(80, 4);
        checkOutput("gap bounded",      int'(timedOut), 0);
        checkOutput("gap D5 noteon",    onCnt[0], 3);
        checkOutput("gap D2 noteon",    onCnt[1], 0);
        checkOutput("rest noteon",      onCnt[2], 0);
        checkOutput("rest pitch",       pitchAt[2], 0);
        checkOutput("rest gap",         strobeAt[3] - strobeAt[2], 10);
        checkOutput("pre-stop noteon",  int'(noteOnB), 1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("stop busy",   int'(busyB),   0);
        checkOutput("stop noteon", int'(noteOnB), 0);
        checkOutput("stop pitch",  int'(pitchB),  0);
        checkOutput("stop addr",   int'(addrB),   0);
        checkOutput("stop done",   int'(doneB),   0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
